// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry and named architectural registers.
// Pure declarations, no logic.
package cpu_pkg;
    localparam int          REG_W    = 32;
    localparam int          REG_AW   = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [4:0]  REG_SP   = 5'd29;
    localparam logic [4:0]  REG_RA   = 5'd31;
endpackage

// File: rtl/dec5to32.sv
// One-hot decoder with enable: drives exactly one row when en=1, none otherwise.
// Latency: combinational. Backpressure: none.
// Used for register write enables and scoreboard set/clear vectors.
module dec5to32
    import cpu_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic              en,
    input  logic [AW-1:0]     addr,
    output logic [2**AW-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with two bypassed read ports and a pending-write scoreboard.
// Latency: reads are combinational; writes and scoreboard updates land on the next clk edge.
// Backpressure: issue_ack drops while a RAW/WAW hazard is present; the issuer holds its request.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_AW,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ack,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  wr_row;
    logic [DEPTH-1:0]  set_row;
    logic [DEPTH-1:0]  clr_row;

    logic wr_live;
    logic issue_set;
    logic byp_a;
    logic byp_b;
    logic waw;
    logic clr;
    logic set_new;
    logic clr_eff;

    assign wr_live   = wr_en && (wr_addr != '0);
    assign byp_a     = (BYPASS != 0) && wr_en && (wr_addr == ra_addr);
    assign byp_b     = (BYPASS != 0) && wr_en && (wr_addr == rb_addr);

    assign ra_data   = (ra_addr == '0) ? '0 : (byp_a ? wr_data : mem[ra_addr]);
    assign rb_data   = (rb_addr == '0) ? '0 : (byp_b ? wr_data : mem[rb_addr]);

    assign busy_a    = pending[ra_addr] && !byp_a;
    assign busy_b    = pending[rb_addr] && !byp_b;
    assign waw       = issue_en && pending[issue_addr] && !(wr_en && (wr_addr == issue_addr));
    assign stall     = busy_a || busy_b || waw;
    assign issue_ack = issue_en && !stall;

    // Address 0 is acknowledged but never becomes a pending producer.
    assign issue_set = issue_ack && (issue_addr != '0);

    dec5to32 #(.AW(ADDR_W)) u_wr_dec  (.en(wr_live),   .addr(wr_addr),    .onehot(wr_row));
    dec5to32 #(.AW(ADDR_W)) u_set_dec (.en(issue_set), .addr(issue_addr), .onehot(set_row));

    assign clr_row = wr_row & pending;
    assign clr     = |clr_row;

    // A retire and a fresh issue to the same register leave it pending with no net count change.
    assign set_new = issue_set && !pending[issue_addr];
    assign clr_eff = clr && !(issue_set && (issue_addr == wr_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_row[i]) begin
                    mem[i] <= wr_data;
                end
            end
            pending  <= (pending & ~clr_row) | set_row;
            pend_cnt <= pend_cnt + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_eff);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard: reset, $0, bypass, RAW, WAW, fill/drain.
module tb_regfile_scoreboard;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra_addr, rb_addr, wr_addr, issue_addr;
    logic [31:0] ra_data, rb_data, wr_data;
    logic        wr_en, issue_en, issue_ack, busy_a, busy_b, stall;
    logic [5:0]  pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .ra_addr    (ra_addr),
        .ra_data    (ra_data),
        .rb_addr    (rb_addr),
        .rb_data    (rb_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .issue_ack  (issue_ack),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .stall      (stall),
        .pend_cnt   (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ra_addr = '0; rb_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
        step();
        rst = 1'b0;
        #1;
        check("rst_pend", 32'(pend_cnt), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // Reset clears the array and overrides a simultaneous write/issue.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0; ra_addr = 5'd5;
        #1;
        check("r5_written", ra_data, 32'hDEADBEEF);
        rst = 1'b1; issue_en = 1'b1; issue_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1;
        step();
        rst = 1'b0; issue_en = 1'b0; wr_en = 1'b0;
        #1;
        check("rst_r5", ra_data, 32'd0);
        check("rst_pend2", 32'(pend_cnt), 32'd0);
        check("rst_stall2", 32'(stall), 32'd0);
        check("rst_ack", 32'(issue_ack), 32'd0);
        ra_addr = 5'd6;
        #1;
        check("rst_wr_ovr", ra_data, 32'd0);

        // $0 ignores writes and issues, still acknowledges.
        wr_en = 1'b1; wr_addr = REG_ZERO; wr_data = 32'hFFFFFFFF; ra_addr = REG_ZERO;
        #1;
        check("z_byp", ra_data, 32'd0);
        step();
        wr_en = 1'b0; issue_en = 1'b1; issue_addr = REG_ZERO;
        #1;
        check("z_ack", 32'(issue_ack), 32'd1);
        step();
        issue_en = 1'b0;
        #1;
        check("z_read", ra_data, 32'd0);
        check("z_pend", 32'(pend_cnt), 32'd0);
        check("z_busy", 32'(busy_a), 32'd0);

        // Same-cycle bypass on both ports.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; ra_addr = 5'd7; rb_addr = 5'd7;
        #1;
        check("byp_a", ra_data, 32'h12345678);
        check("byp_b", rb_data, 32'h12345678);
        step();
        wr_en = 1'b0;
        #1;
        check("arr_a", ra_data, 32'h12345678);
        check("arr_b", rb_data, 32'h12345678);
        ra_addr = '0; rb_addr = '0;

        // RAW hazard and its resolution by writeback.
        issue_en = 1'b1; issue_addr = 5'd9;
        #1;
        check("raw_ack", 32'(issue_ack), 32'd1);
        step();
        issue_en = 1'b0; ra_addr = 5'd9;
        #1;
        check("raw_busy", 32'(busy_a), 32'd1);
        check("raw_stall", 32'(stall), 32'd1);
        check("raw_pend", 32'(pend_cnt), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5;
        #1;
        check("raw_busy_wb", 32'(busy_a), 32'd0);
        check("raw_data_wb", ra_data, 32'hA5);
        check("raw_stall_wb", 32'(stall), 32'd0);
        step();
        wr_en = 1'b0; ra_addr = '0;
        #1;
        check("raw_pend0", 32'(pend_cnt), 32'd0);

        // WAW: blocked without a retire, accepted alongside one.
        issue_en = 1'b1; issue_addr = 5'd3;
        step();
        #1;
        check("waw_ack", 32'(issue_ack), 32'd0);
        check("waw_stall", 32'(stall), 32'd1);
        step();
        check("waw_pend", 32'(pend_cnt), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        check("waw_ack_wb", 32'(issue_ack), 32'd1);
        step();
        wr_en = 1'b0; issue_en = 1'b0; ra_addr = 5'd3;
        #1;
        check("waw_pend_wb", 32'(pend_cnt), 32'd1);
        check("waw_still", 32'(busy_a), 32'd1);
        ra_addr = '0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
        step();
        wr_en = 1'b0;
        #1;
        check("waw_drain", 32'(pend_cnt), 32'd0);

        // Fill every register, then retire in reverse order.
        for (int i = 1; i < 32; i++) begin
            issue_en = 1'b1; issue_addr = 5'(i);
            #1;
            check($sformatf("fill_ack%0d", i), 32'(issue_ack), 32'd1);
            step();
        end
        issue_en = 1'b0;
        #1;
        check("fill_pend", 32'(pend_cnt), 32'd31);
        rb_addr = REG_SP;
        #1;
        check("fill_busy_b", 32'(busy_b), 32'd1);
        rb_addr = '0;
        for (int i = 31; i >= 1; i--) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h11;
            step();
        end
        wr_en = 1'b0;
        #1;
        check("drain_pend", 32'(pend_cnt), 32'd0);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE;
        step();
        wr_en = 1'b0; ra_addr = REG_RA; rb_addr = 5'd5;
        #1;
        check("nopend_wr", 32'(pend_cnt), 32'd0);
        check("ra_val", ra_data, 32'd31 * 32'h11);
        check("r5_val", rb_data, 32'hCAFE);
        check("end_stall", 32'(stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
